div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage sequencer for DIV/DIVU. Sits directly upstream of the iterative Goldschmidt divider and downstream of the EX operand bypass.
- Captures operands, drives the divider's level-held start/ready handshake and stalls the pipeline until the result returns.
- Writes the {remainder, quotient} result into HI/LO and handles flush and abort safely.

Parameters:
- TIMEOUT_CYCLES, 15, maximum cycles in RUN before a forced abort (divider nominal latency is 8).
- CNT_W, 4, width of the RUN cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_div_valid  in  1  DIV/DIVU instruction present in EX.
- ex_div_signed  in  1  1 = DIV, 0 = DIVU.
- ex_src_a  in  32  dividend.
- ex_src_b  in  32  divisor.
- flush  in  1  kill the EX instruction (exception or eret).
- stall_req  out  1  freeze IF/ID/EX.
- div_start  out  1  divider Start; held high for the whole operation.
- div_signed  out  1  divider Signed.
- div_a  out  32  divider A.
- div_b  out  32  divider B.
- div_result  in  64  {remainder[63:32], quotient[31:0]}.
- div_ready  in  1  divider Ready; cleared only after Start drops.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hi_wdata  out  32  remainder.
- lo_wdata  out  32  quotient.
- div_timeout  out  1  one-cycle pulse when the watchdog aborts an operation.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; div_start, hilo_we and div_timeout = 0; div_signed, div_a, div_b, hi_wdata, lo_wdata and the counter = 0.
- State IDLE:
  - ex_div_valid=1 and flush=0: latch the operands into div_a/div_b/div_signed, set div_start=1, clear the counter, go to RUN.
  - flush=1: stay in IDLE.
- State RUN:
  - div_start is held at 1 and div_a/div_b/div_signed are held stable.
  - The counter increments once per cycle.
  - div_ready=1: register hi_wdata=div_result[63:32] and lo_wdata=div_result[31:0]; hilo_we=1 for the next cycle; div_start=0; go to RELEASE.
  - If flush=1 in the same cycle as div_ready=1, flush wins: no write, go to RELEASE.
  - flush=1 without ready: go to ABORT.
  - Counter reaches TIMEOUT_CYCLES: go to ABORT and pulse div_timeout.
- State ABORT:
  - The divider keeps internal state if Start drops early, so div_start must stay 1 here until div_ready=1.
  - On div_ready=1: div_start=0, go to RELEASE. No write.
- State RELEASE:
  - div_start=0.
  - Wait for div_ready=0 (the divider clears Ready on the falling clock edge), then go to IDLE.
  - No new issue is permitted while in RELEASE.
- stall_req is combinational:
  - 1 in IDLE when ex_div_valid && !flush.
  - 1 in RUN when !flush.
  - 1 in ABORT and RELEASE when ex_div_valid && !hilo_we && !flush.
  - 0 otherwise.
  - The retiring instruction is therefore released in the same cycle hilo_we=1.
- Latency: issue cycle + divider latency + 1 cycle to HI/LO write.
- Back-to-back divides: the second one issues at the earliest on the cycle after RELEASE sees div_ready=0.
- Operands are never re-sampled while in RUN or ABORT.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- With it defined:
  - In IDLE, ex_div_valid with ex_src_b==0 does not start the divider.
  - Next cycle: hilo_we=1, hi_wdata=ex_src_a, lo_wdata=32'hFFFFFFFF.
  - stall_req=1 for exactly the issue cycle.
- Without it: a zero divisor is issued to the divider like any other operand, and the result is architecturally undefined.

Decomposition:
- Shared package holds:
  - the state enum: IDLE=2'd0, RUN=2'd1, ABORT=2'd2, RELEASE=2'd3;
  - the DIV_ZERO_LO constant 32'hFFFFFFFF;
  - the default TIMEOUT_CYCLES.
- One sub-module, div_watchdog, is natural: the counter, the compare against TIMEOUT_CYCLES and the div_timeout pulse.
- The FSM and datapath registers stay in div_issue_ctrl.

Test Plan:
- Signed 100 / 7 (divider model, latency 8) -> div_start high for 8 cycles; one hilo_we with hi=2, lo=14; stall_req drops in the same cycle as hilo_we.
- Signed -7 / 2 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFD. Unsigned 32'hFFFFFFFF / 16 -> hi=15, lo=32'h0FFFFFFF.
- Flush asserted on RUN cycle 3 -> div_start stays high until div_ready, then drops; no hilo_we; IDLE is reached only after div_ready=0.
- Two consecutive DIVs -> the second div_start rises only after div_ready is seen low; two hilo_we pulses with the correct data.
- Divider model never asserts ready -> div_timeout pulses after 15 RUN cycles; state is ABORT with div_start still high. Then rst=0 mid-operation -> all outputs are 0 immediately and state is IDLE.
- With DIV_ZERO_BYPASS_EN: 123 / 0 -> div_start never rises; hilo_we next cycle with hi=123, lo=32'hFFFFFFFF.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the DIV/DIVU issue sequencer and its watchdog.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        ABORT   = 2'd2,
        RELEASE = 2'd3
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_LO          = 32'hFFFF_FFFF;
    localparam int unsigned DIV_TIMEOUT_DEFAULT  = 15;
    localparam int unsigned DIV_CNT_W_DEFAULT    = 4;

endpackage

// File: rtl/div_watchdog.sv
// RUN-cycle counter for the divide sequencer; flags expiry and emits a one-cycle
// timeout pulse when the operation is forced into ABORT.
module div_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    input  logic i_cancel,
    output logic o_expire,
    output logic o_timeout
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_timeout;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_expire  = i_run && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign o_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            // A ready or flush in the expiry cycle takes priority, so no pulse then.
            r_timeout <= o_expire && !i_cancel;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_run) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage DIV/DIVU sequencer: operand capture, divider start/ready handshake,
// pipeline stall and HI/LO write-back. Optional zero-divisor bypass: DIV_ZERO_BYPASS_EN.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DIV_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W          = DIV_CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_src_a,
    input  logic [31:0] ex_src_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        hilo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata,
    output logic        div_timeout
);

    div_state_e  r_state;
    div_state_e  w_state_nxt;
    logic        w_issue;
    logic        w_write;
    logic        w_bypass;
    logic        w_stall;
    logic        w_expire;
    logic        r_start;
    logic        r_signed;
    logic [31:0] r_div_a;
    logic [31:0] r_div_b;
    logic        r_hilo_we;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    div_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_issue),
        .i_run     (r_state == RUN),
        .i_cancel  (div_ready || flush),
        .o_expire  (w_expire),
        .o_timeout (div_timeout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_write     = 1'b0;
        w_bypass    = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                // A bypassed zero-divide writes HI/LO from IDLE; that cycle retires it.
                if (ex_div_valid && !flush && !r_hilo_we) begin
                    w_stall = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
                    if (ex_src_b == '0) begin
                        w_bypass = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = RUN;
                    end
`else
                    w_issue     = 1'b1;
                    w_state_nxt = RUN;
`endif
                end
            end
            RUN: begin
                w_stall = !flush;
                if (div_ready) begin
                    w_write     = !flush;
                    w_state_nxt = RELEASE;
                end else if (flush || w_expire) begin
                    w_state_nxt = ABORT;
                end
            end
            ABORT: begin
                w_stall = ex_div_valid && !r_hilo_we && !flush;
                if (div_ready) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                w_stall = ex_div_valid && !r_hilo_we && !flush;
                if (!div_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start   <= 1'b0;
            r_signed  <= 1'b0;
            r_div_a   <= '0;
            r_div_b   <= '0;
            r_hilo_we <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            // Start stays up through ABORT: the divider must finish before Start drops.
            r_start   <= (w_state_nxt == RUN) || (w_state_nxt == ABORT);
            r_hilo_we <= w_write || w_bypass;
            if (w_issue) begin
                r_signed <= ex_div_signed;
                r_div_a  <= ex_src_a;
                r_div_b  <= ex_src_b;
            end
            if (w_write) begin
                r_hi <= div_result[63:32];
                r_lo <= div_result[31:0];
            end else if (w_bypass) begin
                r_hi <= ex_src_a;
                r_lo <= DIV_ZERO_LO;
            end
        end
    end

    assign stall_req  = w_stall;
    assign div_start  = r_start;
    assign div_signed = r_signed;
    assign div_a      = r_div_a;
    assign div_b      = r_div_b;
    assign hilo_we    = r_hilo_we;
    assign hi_wdata   = r_hi;
    assign lo_wdata   = r_lo;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural iterative-divider model.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_div_valid = 1'b0;
    logic        ex_div_signed = 1'b0;
    logic [31:0] ex_src_a = '0;
    logic [31:0] ex_src_b = '0;
    logic        flush = 1'b0;
    logic        stall_req;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [63:0] div_result = '0;
    logic        div_ready = 1'b0;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        div_timeout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          model_lat = 8;
    bit          model_en  = 1'b1;
    int          mcnt      = 0;

    div_issue_ctrl #(
        .TIMEOUT_CYCLES (15),
        .CNT_W          (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_div_valid  (ex_div_valid),
        .ex_div_signed (ex_div_signed),
        .ex_src_a      (ex_src_a),
        .ex_src_b      (ex_src_b),
        .flush         (flush),
        .stall_req     (stall_req),
        .div_start     (div_start),
        .div_signed    (div_signed),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_result    (div_result),
        .div_ready     (div_ready),
        .hilo_we       (hilo_we),
        .hi_wdata      (hi_wdata),
        .lo_wdata      (lo_wdata),
        .div_timeout   (div_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return '0;
        if (sgn) begin
            sa = a;
            sb = b;
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // Divider: raises Ready model_lat cycles after Start, clears it on the falling edge after Start drops.
    always @(negedge clk) begin
        if (!rst || !div_start) begin
            div_ready <= 1'b0;
            mcnt      <= 0;
        end else if (!div_ready && model_en) begin
            if (mcnt + 1 == model_lat) begin
                div_ready  <= 1'b1;
                div_result <= ref_div(div_signed, div_a, div_b);
            end
            mcnt <= mcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One divide from IDLE; flush_cyc < 0 means no flush, else flush driven in that RUN cycle.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int flush_cyc, input bit chk_data);
        logic [63:0] exp;
        logic [31:0] hi_s;
        logic [31:0] lo_s;
        int          starts;
        int          writes;
        int          wr_c;
        bit          tmo;
        bit          exp_stall;
        exp    = ref_div(sgn, a, b);
        starts = 0;
        writes = 0;
        wr_c   = -1;
        tmo    = 1'b0;
        hi_s   = '0;
        lo_s   = '0;
        model_lat = lat;
        chk("pre_start_low", div_start, 1'b0);
        chk("pre_ready_low", div_ready, 1'b0);
        ex_div_valid  = 1'b1;
        ex_div_signed = sgn;
        ex_src_a      = a;
        ex_src_b      = b;
        flush         = 1'b0;
        #1;
        chk("issue_stall", stall_req, 1'b1);
        for (int c = 0; c <= lat; c++) begin
            step();
            flush = 1'b0;
            if (div_start) starts++;
            if (hilo_we) begin
                writes++;
                wr_c = c;
                hi_s = hi_wdata;
                lo_s = lo_wdata;
            end
            if (div_timeout) tmo = 1'b1;
            chk("hold_a", div_a, a);
            chk("hold_b", div_b, b);
            chk("hold_signed", div_signed, sgn);
            if (c == lat) chk("state_release", dut.r_state, RELEASE);
            if (flush_cyc >= 0 && c > flush_cyc) ex_div_valid = 1'b0;
            if (c == flush_cyc) flush = 1'b1;
            if (c < lat) begin
                ex_src_a = $urandom;
                ex_src_b = $urandom;
            end
            exp_stall = !(flush_cyc >= 0 && c >= flush_cyc) && (c != lat);
            #1;
            chk("stall", stall_req, exp_stall);
        end
        step();
        flush        = 1'b0;
        ex_div_valid = 1'b0;
        chk("tail_start", div_start, 1'b0);
        chk("tail_we", hilo_we, 1'b0);
        chk("tail_idle", dut.r_state, IDLE);
        chk("start_cycles", starts, lat);
        chk("timeout_quiet", tmo, 1'b0);
        chk("write_count", writes, (flush_cyc >= 0) ? 0 : 1);
        if (flush_cyc < 0) begin
            chk("write_cycle", wr_c, lat);
            if (chk_data) begin
                chk("hi", hi_s, exp[63:32]);
                chk("lo", lo_s, exp[31:0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          fc;

        #2 rst = 1'b0;
        #1;
        chk("rst_start", div_start, 1'b0);
        chk("rst_we", hilo_we, 1'b0);
        chk("rst_tmo", div_timeout, 1'b0);
        chk("rst_a", div_a, 32'd0);
        chk("rst_hi", hi_wdata, 32'd0);
        chk("rst_state", dut.r_state, IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();

        run_div(1'b1, 32'd100, 32'd7, 8, -1, 1'b1);
        step();
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 8, -1, 1'b1);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd16, 8, -1, 1'b1);
        step();
        run_div(1'b1, 32'd1000, 32'd3, 8, 3, 1'b1);
        run_div(1'b0, 32'd50, 32'd5, 4, 3, 1'b1);
        run_div(1'b1, 32'h8000_0000, 32'd1, 1, -1, 1'b1);

        ex_div_valid = 1'b1;
        flush        = 1'b1;
        ex_src_b     = 32'd9;
        #1;
        chk("flush_idle_stall", stall_req, 1'b0);
        step();
        chk("flush_idle_nostart", div_start, 1'b0);
        ex_div_valid = 1'b0;
        flush        = 1'b0;
        step();

`ifdef DIV_ZERO_BYPASS_EN
        ex_div_valid  = 1'b1;
        ex_div_signed = 1'b1;
        ex_src_a      = 32'd123;
        ex_src_b      = 32'd0;
        #1;
        chk("bypass_stall", stall_req, 1'b1);
        step();
        chk("bypass_nostart", div_start, 1'b0);
        chk("bypass_we", hilo_we, 1'b1);
        chk("bypass_hi", hi_wdata, 32'd123);
        chk("bypass_lo", lo_wdata, 32'hFFFF_FFFF);
        chk("bypass_release", stall_req, 1'b0);
        ex_div_valid = 1'b0;
        step();
        chk("bypass_we_once", hilo_we, 1'b0);
        chk("bypass_nostart2", div_start, 1'b0);
`else
        run_div(1'b0, 32'd123, 32'd0, 6, -1, 1'b0);
`endif
        step();

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 20));
            if (b == 32'd0) b = 32'd1;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            lat = $urandom_range(1, 12);
            fc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, lat - 1)) : -1;
            run_div(sgn, a, b, lat, fc, 1'b1);
            repeat ($urandom_range(0, 2)) step();
        end

        model_en      = 1'b0;
        ex_div_valid  = 1'b1;
        ex_div_signed = 1'b0;
        ex_src_a      = 32'hDEAD_BEEF;
        ex_src_b      = 32'd5;
        #1;
        for (int c = 0; c <= 16; c++) begin
            step();
            chk("wd_pulse", div_timeout, (c == 15));
            chk("wd_start_held", div_start, 1'b1);
            chk("wd_stall", stall_req, 1'b1);
            if (c == 15) chk("wd_state_abort", dut.r_state, ABORT);
        end
        ex_div_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_start", div_start, 1'b0);
        chk("arst_we", hilo_we, 1'b0);
        chk("arst_tmo", div_timeout, 1'b0);
        chk("arst_signed", div_signed, 1'b0);
        chk("arst_a", div_a, 32'd0);
        chk("arst_b", div_b, 32'd0);
        chk("arst_lo", lo_wdata, 32'd0);
        chk("arst_state", dut.r_state, IDLE);
        @(negedge clk) rst = 1'b1;
        model_en = 1'b1;
        step();
        step();
        run_div(1'b1, 32'd77, 32'hFFFF_FFF5, 3, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
